// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small in-order queue feeding decode.
// Issues sequential/predicted fetches and flushes on execute-stage redirects.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] bp_pc,
    input  logic        bp_taken,
    input  logic [31:0] bp_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dq_valid,
    input  logic        dq_ready,
    output logic [31:0] dq_pc,
    output logic [31:0] dq_instruction,
    output logic [31:0] dq_pc_target,
    output logic        dq_taken
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] target;
        logic        taken;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             entries_q [DEPTH];

    logic               enq;
    logic               deq;
    logic [31:0]        next_pc;
    entry_t             enq_entry;
    entry_t             head_entry;

    assign next_pc   = bp_taken ? bp_target : fetch_pc_q + 32'd4;
    assign enq_entry = '{pc: fetch_pc_q, instr: imem_rdata, target: next_pc, taken: bp_taken};

    assign enq = !redirect && (state_q == REQ) && imem_resp;
    assign deq = !redirect && dq_valid && dq_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (redirect) begin
            count_d    = '0;
            head_d     = tail_q;
            fetch_pc_d = redirect_pc;
            unique case (state_q)
                IDLE:    state_d = IDLE;
                REQ:     state_d = imem_resp ? IDLE : DISCARD;
                // A response landing with the redirect is the stale one; waiting on would deadlock.
                DISCARD: state_d = imem_resp ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else begin
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            if (enq) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = next_pc;
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CNT_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (count_q < CNT_W'(DEPTH)) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (imem_resp) begin
                        state_d = (count_d < CNT_W'(DEPTH)) ? REQ : IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage carries no reset; contents only matter while counted valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[tail_q] <= enq_entry;
        end
    end

    assign head_entry = entries_q[head_q];

    assign imem_read      = (state_q == REQ);
    assign imem_addr      = fetch_pc_q;
    assign bp_pc          = fetch_pc_q;
    assign dq_valid       = (count_q != '0);
    assign dq_pc          = head_entry.pc;
    assign dq_instruction = head_entry.instr;
    assign dq_pc_target   = head_entry.target;
    assign dq_taken       = head_entry.taken;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, prediction, back-pressure,
// redirect flushes and asynchronous reset, with hand-computed expectations.
module tb_fetch_queue;

    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] bp_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dq_valid;
    logic        dq_ready;
    logic [31:0] dq_pc;
    logic [31:0] dq_instruction;
    logic [31:0] dq_pc_target;
    logic        dq_taken;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Responder and predictor controls
    logic        auto_en  = 1'b0;
    int unsigned lat      = 1;
    int unsigned rd_age   = 0;
    logic        pred_en  = 1'b0;
    logic [31:0] pred_pc  = '0;
    logic [31:0] pred_tgt = '0;

    logic [31:0] issued [$];
    logic [31:0] dqr_pc [$];
    logic [31:0] dqr_ins [$];
    logic [31:0] dqr_tgt [$];
    logic        dqr_tkn [$];

    fetch_queue #(
        .DEPTH   (4),
        .RESET_PC(32'h6000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_resp     (imem_resp),
        .bp_pc         (bp_pc),
        .bp_taken      (bp_taken),
        .bp_target     (bp_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .dq_valid      (dq_valid),
        .dq_ready      (dq_ready),
        .dq_pc         (dq_pc),
        .dq_instruction(dq_instruction),
        .dq_pc_target  (dq_pc_target),
        .dq_taken      (dq_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sets inputs for the coming edge, logs handshakes, then samples 1 time unit after it.
    task automatic step();
        if (pred_en && bp_pc == pred_pc) begin
            bp_taken  = 1'b1;
            bp_target = pred_tgt;
        end else begin
            bp_taken  = 1'b0;
            bp_target = 32'hDEAD_BEEF;
        end
        if (auto_en) begin
            imem_resp = 1'b0;
            if (imem_read) begin
                if (rd_age >= lat) begin
                    imem_resp = 1'b1;
                    rd_age    = 0;
                end else begin
                    rd_age++;
                end
            end else begin
                rd_age = 0;
            end
        end
        imem_rdata = imem_addr ^ IMASK;
        if (imem_resp && imem_read && !redirect) issued.push_back(imem_addr);
        if (dq_valid && dq_ready && !redirect) begin
            dqr_pc.push_back(dq_pc);
            dqr_ins.push_back(dq_instruction);
            dqr_tgt.push_back(dq_pc_target);
            dqr_tkn.push_back(dq_taken);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_age = 0;
        issued.delete();
        dqr_pc.delete();
        dqr_ins.delete();
        dqr_tgt.delete();
        dqr_tkn.delete();
    endtask

    task automatic wait_read(input string tag);
        int unsigned n = 0;
        while (!imem_read && n < 20) begin
            step();
            n++;
        end
        check(tag, {31'd0, imem_read}, 32'd1);
    endtask

    initial begin
        int unsigned n;
        rst         = 1'b1;
        imem_rdata  = '0;
        imem_resp   = 1'b0;
        bp_taken    = 1'b0;
        bp_target   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dq_ready    = 1'b0;
        do_reset();

        check("rst_read",  {31'd0, imem_read}, 32'd0);
        check("rst_valid", {31'd0, dq_valid},  32'd0);
        check("rst_addr",  imem_addr, 32'h6000_0000);
        check("rst_bppc",  bp_pc,     32'h6000_0000);

        // Sequential fetch with one predicted-taken branch at 0x60000008
        auto_en  = 1'b1;
        lat      = 1;
        dq_ready = 1'b1;
        pred_en  = 1'b1;
        pred_pc  = 32'h6000_0008;
        pred_tgt = 32'h6000_0100;
        n = 0;
        while ((issued.size() < 5 || dqr_pc.size() < 4) && n < 60) begin
            step();
            n++;
        end
        check("seq_nissued", 32'(issued.size() >= 5), 32'd1);
        check("seq_ndeq",    32'(dqr_pc.size() >= 4), 32'd1);
        if (issued.size() >= 5 && dqr_pc.size() >= 4) begin
            check("seq_addr0", issued[0], 32'h6000_0000);
            check("seq_addr1", issued[1], 32'h6000_0004);
            check("seq_addr2", issued[2], 32'h6000_0008);
            check("seq_addr3", issued[3], 32'h6000_0100);
            check("seq_addr4", issued[4], 32'h6000_0104);
            check("seq_pc0",   dqr_pc[0],  32'h6000_0000);
            check("seq_ins0",  dqr_ins[0], 32'h6000_0000 ^ IMASK);
            check("seq_tgt0",  dqr_tgt[0], 32'h6000_0004);
            check("seq_tkn0",  {31'd0, dqr_tkn[0]}, 32'd0);
            check("seq_pc1",   dqr_pc[1],  32'h6000_0004);
            check("seq_tgt1",  dqr_tgt[1], 32'h6000_0008);
            check("seq_pc2",   dqr_pc[2],  32'h6000_0008);
            check("seq_tgt2",  dqr_tgt[2], 32'h6000_0100);
            check("seq_tkn2",  {31'd0, dqr_tkn[2]}, 32'd1);
            check("seq_pc3",   dqr_pc[3],  32'h6000_0100);
            check("seq_tgt3",  dqr_tgt[3], 32'h6000_0104);
        end

        // Back-pressure: queue fills to DEPTH then fetch stops
        pred_en  = 1'b0;
        dq_ready = 1'b0;
        do_reset();
        repeat (30) step();
        check("full_nissued", 32'(issued.size()), 32'd4);
        check("full_read",    {31'd0, imem_read}, 32'd0);
        check("full_valid",   {31'd0, dq_valid},  32'd1);
        check("full_head",    dq_pc, 32'h6000_0000);
        dq_ready = 1'b1;
        step();
        dq_ready = 1'b0;
        repeat (10) step();
        check("refill_nissued", 32'(issued.size()), 32'd5);
        if (issued.size() == 5) check("refill_addr", issued[4], 32'h6000_0010);
        check("refill_read",  {31'd0, imem_read}, 32'd0);
        check("refill_ndeq",  32'(dqr_pc.size()), 32'd1);
        check("refill_head",  dq_pc, 32'h6000_0004);
        check("refill_tgt",   dq_pc_target, 32'h6000_0008);

        // Redirect with a request outstanding; stale response arrives 3 cycles later
        auto_en   = 1'b0;
        imem_resp = 1'b0;
        do_reset();
        wait_read("rd1_wait");
        imem_resp = 1'b1;
        step();
        imem_resp = 1'b0;
        check("rd1_valid_pre", {31'd0, dq_valid}, 32'd1);
        check("rd1_addr_pre",  imem_addr, 32'h6000_0004);
        redirect    = 1'b1;
        redirect_pc = 32'h6000_0200;
        step();
        redirect = 1'b0;
        check("rd1_valid", {31'd0, dq_valid},  32'd0);
        check("rd1_read",  {31'd0, imem_read}, 32'd0);
        step();
        step();
        imem_resp = 1'b1;
        step();
        imem_resp = 1'b0;
        check("rd1_drop_valid", {31'd0, dq_valid},  32'd0);
        check("rd1_drop_read",  {31'd0, imem_read}, 32'd0);
        step();
        check("rd1_new_read", {31'd0, imem_read}, 32'd1);
        check("rd1_new_addr", imem_addr, 32'h6000_0200);

        // Redirect coinciding with a response while 2 entries are queued
        imem_resp = 1'b1;
        step();
        step();
        check("rd2_addr_pre", imem_addr, 32'h6000_0208);
        check("rd2_head_pre", dq_pc, 32'h6000_0200);
        redirect    = 1'b1;
        redirect_pc = 32'h6000_0300;
        step();
        redirect  = 1'b0;
        imem_resp = 1'b0;
        check("rd2_valid", {31'd0, dq_valid},  32'd0);
        check("rd2_read",  {31'd0, imem_read}, 32'd0);
        step();
        check("rd2_new_read", {31'd0, imem_read}, 32'd1);
        check("rd2_new_addr", imem_addr, 32'h6000_0300);
        imem_resp = 1'b1;
        step();
        imem_resp = 1'b0;
        check("rd2_head",     dq_pc, 32'h6000_0300);
        check("rd2_head_ins", dq_instruction, 32'h6000_0300 ^ IMASK);
        check("rd2_head_tgt", dq_pc_target, 32'h6000_0304);

        // Asynchronous reset while a request is outstanding
        check("ar_read_pre", {31'd0, imem_read}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_read",  {31'd0, imem_read}, 32'd0);
        check("ar_valid", {31'd0, dq_valid},  32'd0);
        check("ar_addr",  imem_addr, 32'h6000_0000);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("ar_new_read", {31'd0, imem_read}, 32'd1);
        check("ar_new_addr", imem_addr, 32'h6000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
